// File: rtl/fadd_rs_pkg.sv
// Shared types for the FP-add reservation station: geometry, entry layout, FSM states.
// No logic lives here apart from the CDB tag-match helper.
package fadd_rs_pkg;

  localparam int NUM_RS = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int AGE_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int IDX_W  = AGE_W;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } fsm_state_t;

  // age counts how many valid entries were dispatched before this one
  typedef struct packed {
    logic              valid;
    logic              issued;
    logic              sub;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [AGE_W-1:0]  age;
  } rs_entry_t;

  function automatic logic tag_match(input logic vld, input logic [TAG_W-1:0] q,
                                     input logic [TAG_W-1:0] t);
    return vld && (q != TAG_NONE) && (q == t);
  endfunction

endpackage

// File: rtl/fadd_rs_ctrl_if.sv
// Dispatch, CDB snoop, adder operand/result and CDB-request signals of the FP-add station.
// master = the controller, slave = the surrounding pipeline / testbench.
interface fadd_rs_ctrl_if;
  import fadd_rs_pkg::*;

  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic              disp_sub;
  logic [TAG_W-1:0]  disp_qj;
  logic [TAG_W-1:0]  disp_qk;
  logic [DATA_W-1:0] disp_vj;
  logic [DATA_W-1:0] disp_vk;
  logic [TAG_W-1:0]  disp_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [DATA_W-1:0] fu_x1;
  logic [DATA_W-1:0] fu_x2;
  logic [DATA_W-1:0] fu_x3;
  logic              res_valid;
  logic              res_ready;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_data;
  logic [NUM_RS-1:0] busy_mask;

  modport master (
    input  flush, disp_valid, disp_sub, disp_qj, disp_qk, disp_vj, disp_vk,
           cdb_valid, cdb_tag, cdb_data, fu_x3, res_ready,
    output disp_ready, disp_tag, fu_x1, fu_x2, res_valid, res_tag, res_data, busy_mask
  );

  modport slave (
    output flush, disp_valid, disp_sub, disp_qj, disp_qk, disp_vj, disp_vk,
           cdb_valid, cdb_tag, cdb_data, fu_x3, res_ready,
    input  disp_ready, disp_tag, fu_x1, fu_x2, res_valid, res_tag, res_data, busy_mask
  );

endinterface

// File: rtl/fadd_rs_age_select.sv
// Picks the oldest ready entry (smallest age) as a one-hot grant; purely combinational.
// Ages of valid entries are unique, so no tie-break is needed.
module fadd_rs_age_select
  import fadd_rs_pkg::*;
(
  input  logic [NUM_RS-1:0]            ready,
  input  logic [NUM_RS-1:0][AGE_W-1:0] age,
  output logic [NUM_RS-1:0]            grant,
  output logic                         grant_vld
);

  logic [AGE_W-1:0] best_age;
  logic [IDX_W-1:0] best_idx;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    best_age  = '0;
    best_idx  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (ready[i] && (!grant_vld || age[i] < best_age)) begin
        grant_vld = 1'b1;
        best_age  = age[i];
        best_idx  = IDX_W'(i);
      end
    end
    if (grant_vld) grant[best_idx] = 1'b1;
  end

endmodule

// File: rtl/fadd_rs_ctrl.sv
// FADD/FSUB reservation station driving one shared adder; result valid LAT edges after issue,
// held until res_ready. FADD_RS_PERF_EN adds saturating issue/stall counters.
module fadd_rs_ctrl
  import fadd_rs_pkg::*;
#(
  parameter int TAG_BASE = 1,
  parameter int LAT      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fadd_rs_ctrl_if.master       bus
`ifdef FADD_RS_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall
`endif
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  rs_entry_t                   rs [NUM_RS];
  logic [NUM_RS-1:0]           valid_vec, ready_vec, grant;
  logic [NUM_RS-1:0][AGE_W-1:0] age_vec;
  logic                        grant_vld, free_found;
  logic [IDX_W-1:0]            grant_idx, free_idx, fly_idx;
  logic [AGE_W-1:0]            fly_age, new_age;
  rs_entry_t                   new_entry;

  fsm_state_t                  state;
  logic [CNT_W-1:0]            cnt;
  logic [DATA_W-1:0]           fu_x1_q, fu_x2_q, res_data_q;
  logic [TAG_W-1:0]            res_tag_q;
  logic                        res_valid_q;
  logic                        disp_fire, accept, issue_fire, free_fire;

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    age_vec   = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      valid_vec[i] = rs[i].valid;
      ready_vec[i] = rs[i].valid && !rs[i].issued &&
                     (rs[i].qj == TAG_NONE) && (rs[i].qk == TAG_NONE);
      age_vec[i]   = rs[i].age;
    end
  end

  fadd_rs_age_select u_age_select (
    .ready     (ready_vec),
    .age       (age_vec),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  always_comb begin
    grant_idx  = '0;
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Freed slot stays invisible to dispatch until next cycle: free_found uses pre-edge valids.
  assign disp_fire  = bus.disp_valid && free_found && !bus.flush;
  assign accept     = (state == WB) && res_valid_q && bus.res_ready;
  assign free_fire  = accept && !bus.flush;
  assign issue_fire = grant_vld && !bus.flush && ((state == IDLE) || accept);
  assign fly_age    = rs[fly_idx].age;

  // New entry is younger than everything that survives this edge.
  always_comb begin
    new_age = AGE_W'($countones(valid_vec) - (free_fire ? 1 : 0));
    new_entry        = '0;
    new_entry.valid  = 1'b1;
    new_entry.sub    = bus.disp_sub;
    new_entry.age    = new_age;
    new_entry.qj     = bus.disp_qj;
    new_entry.vj     = bus.disp_vj;
    new_entry.qk     = bus.disp_qk;
    new_entry.vk     = bus.disp_vk;
    if (tag_match(bus.cdb_valid, bus.disp_qj, bus.cdb_tag)) begin
      new_entry.qj = TAG_NONE;
      new_entry.vj = bus.cdb_data;
    end
    if (tag_match(bus.cdb_valid, bus.disp_qk, bus.cdb_tag)) begin
      new_entry.qk = TAG_NONE;
      new_entry.vk = bus.cdb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RS; i++) rs[i] <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_RS; i++) rs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (free_fire && fly_idx == IDX_W'(i)) begin
          rs[i] <= '0;
        end else if (rs[i].valid) begin
          if (tag_match(bus.cdb_valid, rs[i].qj, bus.cdb_tag)) begin
            rs[i].qj <= TAG_NONE;
            rs[i].vj <= bus.cdb_data;
          end
          if (tag_match(bus.cdb_valid, rs[i].qk, bus.cdb_tag)) begin
            rs[i].qk <= TAG_NONE;
            rs[i].vk <= bus.cdb_data;
          end
          if (free_fire && rs[i].age > fly_age) rs[i].age <= rs[i].age - AGE_W'(1);
          if (issue_fire && grant[i]) rs[i].issued <= 1'b1;
        end else if (disp_fire && free_idx == IDX_W'(i)) begin
          rs[i] <= new_entry;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      fly_idx     <= '0;
      fu_x1_q     <= '0;
      fu_x2_q     <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else if (bus.flush) begin
      state       <= IDLE;
      res_valid_q <= 1'b0;
    end else begin
      if (accept) res_valid_q <= 1'b0;
      if (issue_fire) begin
        fu_x1_q <= rs[grant_idx].vj;
        fu_x2_q <= rs[grant_idx].vk ^ {rs[grant_idx].sub, {(DATA_W-1){1'b0}}};
        fly_idx <= grant_idx;
        cnt     <= CNT_W'(LAT - 1);
        state   <= EXEC;
      end else begin
        case (state)
          IDLE: ;
          EXEC: begin
            if (cnt == '0) begin
              res_data_q  <= bus.fu_x3;
              res_tag_q   <= TAG_W'(TAG_BASE + int'(fly_idx));
              res_valid_q <= 1'b1;
              state       <= WB;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          WB:      if (accept) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.disp_ready = free_found;
  assign bus.disp_tag   = TAG_W'(TAG_BASE + int'(free_idx));
  assign bus.fu_x1      = fu_x1_q;
  assign bus.fu_x2      = fu_x2_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.res_data   = res_data_q;
  assign bus.busy_mask  = valid_vec;

`ifdef FADD_RS_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (bus.flush) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue_fire && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if (state == WB && !bus.res_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fadd_rs_ctrl.sv
// Directed bench for fadd_rs_ctrl with a lookup-table stand-in for the FP adder.
module tb_fadd_rs_ctrl;
  import fadd_rs_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  fadd_rs_ctrl_if bus ();

`ifdef FADD_RS_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  fadd_rs_ctrl #(.TAG_BASE(1), .LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FADD_RS_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact IEEE-754 sums for every operand pair this bench feeds the adder; NaN otherwise.
  function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h0000_0000, 32'h0000_0000}: return 32'h0000_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h40A0_0000, 32'h3F80_0000}: return 32'h40C0_0000;
      {32'h4040_0000, 32'hBF80_0000}: return 32'h4000_0000;
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      {32'h4040_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {32'h4080_0000, 32'h4080_0000}: return 32'h4100_0000;
      default:                        return 32'h7FC0_0000;
    endcase
  endfunction

  always_comb bus.fu_x3 = fadd_model(bus.fu_x1, bus.fu_x2);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic sub, input logic [3:0] qj, input logic [31:0] vj,
                      input logic [3:0] qk, input logic [31:0] vk);
    bus.disp_valid = 1'b1;
    bus.disp_sub   = sub;
    bus.disp_qj    = qj;
    bus.disp_vj    = vj;
    bus.disp_qk    = qk;
    bus.disp_vk    = vk;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!bus.res_valid && n < 12) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.res_valid), 32'd1);
  endtask

  logic [31:0] fill_a [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
  logic [31:0] fill_r [4] = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};

  initial begin
    logic seen;
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_sub   = 1'b0;
    bus.disp_qj    = '0;
    bus.disp_qk    = '0;
    bus.disp_vj    = '0;
    bus.disp_vk    = '0;
    bus.cdb_valid  = 1'b0;
    bus.cdb_tag    = '0;
    bus.cdb_data   = '0;
    bus.res_ready  = 1'b0;

    #3;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy_mask), 32'd0);
    chk("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
    chk("rst_disp_tag", 32'(bus.disp_tag), 32'd1);
    chk("rst_fu_x1", bus.fu_x1, 32'd0);
`ifdef FADD_RS_PERF_EN
    chk("rst_perf_issued", perf_issued, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1.0 + 2.0, both operands ready
    disp(1'b0, 4'd0, 32'h3F80_0000, 4'd0, 32'h4000_0000);
    chk("add_disp_tag", 32'(bus.disp_tag), 32'd1);
    step();
    bus.disp_valid = 1'b0;
    chk("add_busy", 32'(bus.busy_mask), 32'd1);
    step();
    chk("add_issue_x1", bus.fu_x1, 32'h3F80_0000);
    step();
    chk("add_lat_early", 32'(bus.res_valid), 32'd0);
    step();
    chk("add_res_valid", 32'(bus.res_valid), 32'd1);
    chk("add_res_data", bus.res_data, 32'h4040_0000);
    chk("add_res_tag", 32'(bus.res_tag), 32'd1);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("add_accept_valid", 32'(bus.res_valid), 32'd0);
    chk("add_accept_busy", 32'(bus.busy_mask), 32'd0);

    // qj waits on tag 5, delivered on the CDB a few cycles later
    disp(1'b0, 4'd5, 32'h1234_5678, 4'd0, 32'h3F80_0000);
    step();
    bus.disp_valid = 1'b0;
    step();
    step();
    chk("cdb_wait_no_issue", bus.fu_x1, 32'h3F80_0000);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 4'd5;
    bus.cdb_data  = 32'h40A0_0000;
    step();
    bus.cdb_valid = 1'b0;
    chk("cdb_capture_no_issue", bus.fu_x1, 32'h3F80_0000);
    step();
    chk("cdb_issue_x1", bus.fu_x1, 32'h40A0_0000);
    chk("cdb_issue_x2", bus.fu_x2, 32'h3F80_0000);
    step();
    step();
    chk("cdb_res_valid", 32'(bus.res_valid), 32'd1);
    chk("cdb_res_data", bus.res_data, 32'h40C0_0000);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // Same operation with the CDB broadcast in the dispatch cycle
    disp(1'b0, 4'd5, 32'h1234_5678, 4'd0, 32'h3F80_0000);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 4'd5;
    bus.cdb_data  = 32'h40A0_0000;
    step();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    step();
    step();
    chk("byp_lat_early", 32'(bus.res_valid), 32'd0);
    step();
    chk("byp_res_valid", 32'(bus.res_valid), 32'd1);
    chk("byp_res_data", bus.res_data, 32'h40C0_0000);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // 3.0 - 1.0
    disp(1'b1, 4'd0, 32'h4040_0000, 4'd0, 32'h3F80_0000);
    step();
    bus.disp_valid = 1'b0;
    step();
    chk("sub_fu_x2", bus.fu_x2, 32'hBF80_0000);
    step();
    step();
    chk("sub_res_data", bus.res_data, 32'h4000_0000);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // Fill all four entries, then stall the result
    for (int k = 0; k < 4; k++) begin
      disp(1'b0, 4'd0, fill_a[k], 4'd0, fill_a[k]);
      chk($sformatf("fill_tag%0d", k), 32'(bus.disp_tag), 32'(k + 1));
      step();
    end
    disp(1'b0, 4'd0, 32'h4120_0000, 4'd0, 32'h4120_0000);
    chk("full_disp_ready", 32'(bus.disp_ready), 32'd0);
    chk("full_busy", 32'(bus.busy_mask), 32'hF);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hold_valid%0d", k), 32'(bus.res_valid), 32'd1);
      chk($sformatf("hold_data%0d", k), bus.res_data, 32'h4000_0000);
      chk($sformatf("hold_tag%0d", k), 32'(bus.res_tag), 32'd1);
      step();
      bus.disp_valid = 1'b0;
    end
    bus.res_ready = 1'b1;
    chk("accept_edge_not_ready", 32'(bus.disp_ready), 32'd0);
    step();
    chk("after_accept_ready", 32'(bus.disp_ready), 32'd1);
    chk("after_accept_busy", 32'(bus.busy_mask), 32'hE);
    chk("after_accept_reissue", bus.fu_x1, 32'h4000_0000);
    for (int k = 1; k < 4; k++) begin
      wait_res($sformatf("order_wait%0d", k));
      chk($sformatf("order_tag%0d", k), 32'(bus.res_tag), 32'(k + 1));
      chk($sformatf("order_data%0d", k), bus.res_data, fill_r[k]);
      step();
    end
    step();
    step();
    step();
    chk("drain_busy", 32'(bus.busy_mask), 32'd0);
    chk("drain_no_ghost", 32'(bus.res_valid), 32'd0);
    bus.res_ready = 1'b0;

    // Flush with three entries while the oldest is in EXEC
    for (int k = 0; k < 3; k++) begin
      disp(1'b0, 4'd0, 32'h3F80_0000, 4'd0, 32'h3F80_0000);
      step();
    end
    chk("pre_flush_busy", 32'(bus.busy_mask), 32'h7);
    bus.flush = 1'b1;
    step();
    bus.flush      = 1'b0;
    bus.disp_valid = 1'b0;
    chk("flush_busy", 32'(bus.busy_mask), 32'd0);
    chk("flush_res_valid", 32'(bus.res_valid), 32'd0);
    chk("flush_disp_ready", 32'(bus.disp_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen = seen | bus.res_valid;
      step();
    end
    chk("flush_never_valid", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of EXEC
    disp(1'b0, 4'd0, 32'h3F80_0000, 4'd0, 32'h3F80_0000);
    step();
    bus.disp_valid = 1'b0;
    step();
    chk("pre_rst_busy", 32'(bus.busy_mask), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy_mask), 32'd0);
    chk("arst_disp_ready", 32'(bus.disp_ready), 32'd1);
    chk("arst_fu_x1", bus.fu_x1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("post_rst_idle", 32'(bus.res_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fadd_rs_ctrl.md
Name: fadd_rs_ctrl

Overview:
Reservation-station controller that shares one combinational FP adder (fpADD_32) between NUM_RS waiting FADD/FSUB instructions.
- Accepts dispatched instructions with operand tags/values and snoops the CDB for pending operands.
- Issues the oldest ready entry to the adder and holds the result until the CDB arbiter accepts it.
- Non-pipelined: one operation in flight at a time.

Parameters:
NUM_RS, 4, number of reservation-station entries
TAG_W, 4, CDB tag width; tag 0 = "value ready / no producer"
DATA_W, 32, operand/result width (IEEE-754 single)
TAG_BASE, 1, tag of entry 0; entry i owns tag TAG_BASE+i (nonzero, unique per unit)
LAT, 2, adder occupancy in cycles (≥1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous squash of all entries and in-flight op
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one free entry
disp_sub  in  1  1 = subtract (X1 − X2)
disp_qj, disp_qk  in  TAG_W  producer tags for operands j/k; 0 = ready
disp_vj, disp_vk  in  DATA_W  operand values, valid when matching q = 0
disp_tag  out  TAG_W  tag allocated this cycle (lowest free index)
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB tag
cdb_data  in  DATA_W  CDB value
fu_x1, fu_x2  out  DATA_W  registered adder operands
fu_x3  in  DATA_W  adder result (combinational from fu_x1/fu_x2)
res_valid  out  1  result request to CDB arbiter
res_ready  in  1  CDB grant
res_tag  out  TAG_W  result tag
res_data  out  DATA_W  result value
busy_mask  out  NUM_RS  per-entry occupied flag

Behaviour:
- Reset: all entries invalid; state IDLE; res_valid, res_tag, res_data, fu_x1, fu_x2, busy_mask = 0. disp_ready = 1 (combinational, = any free entry). disp_tag = TAG_BASE.
- Dispatch:
  - disp_valid & disp_ready writes the lowest free index, with age = youngest.
  - Operand with q = 0 stores v. Operand with q = cdb_tag while cdb_valid in the same cycle stores cdb_data with q = 0 (same-cycle bypass).
  - disp_valid while disp_ready = 0 is ignored.
- Snoop: every cycle, each valid entry with qj or qk equal to cdb_tag (cdb_valid = 1) captures cdb_data and clears that q.
- Ready: entry valid, qj = qk = 0, not issued. A value captured at edge T makes the entry eligible in cycle T+1.
- FSM IDLE → EXEC → WB:
  - IDLE: if any ready entry, select the oldest by dispatch order. At the edge, latch fu_x1 = vj, fu_x2 = vk with bit 31 inverted if sub, latch in-flight tag and index, cnt = LAT−1, go to EXEC.
  - EXEC: if cnt = 0, latch res_data = fu_x3, res_tag, res_valid = 1, go to WB; else cnt−−.
  - WB: res_valid/res_tag/res_data held stable until res_valid & res_ready. On that edge: free the entry, clear res_valid. If another entry is ready, issue it on the same edge (go to EXEC); else go to IDLE.
- Latency: res_valid rises exactly LAT edges after the issue edge.
- An entry stays valid (tag reserved, counted in busy_mask) until its result is accepted.
- Flush: on that edge, all entries invalid, state IDLE, res_valid = 0, in-flight result dropped. Dispatch in the same cycle is ignored. Flush overrides res_ready.
- Simultaneous dispatch and free: the freed slot is not visible to disp_ready until the next cycle.
- Sign flip for sub is the only arithmetic in this block. Overflow, zero and denormal handling belong to the adder.

Optional Feature:
FADD_RS_PERF_EN:
- When defined: adds outputs perf_issued (32, issue count) and perf_stall (32, cycles in WB with res_ready = 0). Both are saturating, reset to 0, and cleared by flush.
- When undefined: ports and logic are absent.

Decomposition:
- Package fadd_rs_pkg: FSM state enum (IDLE, EXEC, WB), rs_entry struct (valid, issued, sub, qj, qk, vj, vk, age), constant TAG_NONE = 0.
- Sub-module fadd_rs_age_select: ready vector + age fields → one-hot grant + valid. Purely combinational; priority is oldest first.

Test Plan:
- Reset asserted mid-EXEC → res_valid = 0, busy_mask = 0, disp_ready = 1 immediately (asynchronous).
- Dispatch add 0x3F800000 + 0x40000000, both ready → disp_tag = 1; res_valid after 2 edges with res_data = 0x40400000, res_tag = 1; busy_mask = 0 after accept.
- Dispatch qj = 5, vk = 0x3F800000; 3 cycles later CDB tag 5 = 0x40A00000 → issue next cycle, res_data = 0x40C00000. Repeat with CDB in the dispatch cycle → same result, one cycle earlier.
- Sub 0x40400000 − 0x3F800000 → fu_x2 = 0xBF800000, res_data = 0x40000000.
- Fill 4 entries → disp_ready = 0. Hold res_ready = 0 for 10 cycles → res_valid/res_data stable; issue order matches dispatch order; disp_ready = 1 one cycle after first accept.
- Flush during EXEC with 3 entries → no res_valid ever asserted for them; busy_mask = 0 next cycle.
